// File: rtl/serial_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one 8N1 serial transmitter.
// Frames are start(0), 8 data bits LSB first, stop(1); each bit lasts BIT_CYCLES clocks.
module serial_tx_arbiter #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  state_t     state;
  logic [7:0] cyc_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;

  logic       bit_end;
  logic       accept_window;
  logic       winner;
  logic       accept;
  logic [7:0] win_data;

  // Handshake: a byte transfers in a cycle where reqN_valid and reqN_ready are both
  // high; ready only rises in IDLE or the last STOP cycle, and never for both requesters.
  always_comb begin
    bit_end       = (cyc_cnt == LAST);
    accept_window = !reset && ((state == IDLE) || ((state == STOP) && bit_end));
    winner        = (req0_valid && req1_valid) ? ~grant_id : req1_valid;
    req0_ready    = accept_window && req0_valid && !winner;
    req1_ready    = accept_window && req1_valid && winner;
    accept        = req0_ready || req1_ready;
    win_data      = winner ? req1_data : req0_data;
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      grant_id   <= 1'b1;
      frame_done <= 1'b0;
      cyc_cnt    <= 8'd0;
      bit_cnt    <= 3'd0;
      shift_q    <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            shift_q  <= win_data;
            grant_id <= winner;
            cyc_cnt  <= 8'd0;
            tx       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            cyc_cnt <= 8'd0;
            bit_cnt <= 3'd0;
            tx      <= shift_q[0];
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_cnt <= 8'd0;
            if (bit_cnt == 3'd7) begin
              state      <= STOP;
              tx         <= 1'b1;
              // With one-cycle bits the first STOP cycle is also the last.
              frame_done <= (LAST == 8'd0);
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift_q <= shift_q >> 1;
              tx      <= shift_q[1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cyc_cnt <= 8'd0;
            if (accept) begin
              state    <= START;
              shift_q  <= win_data;
              grant_id <= winner;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            cyc_cnt    <= cyc_cnt + 8'd1;
            frame_done <= (cyc_cnt == LAST - 8'd1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: two instances (BIT_CYCLES 1 and 4) share stimulus;
// a frame-level model expands each accepted byte into its expected per-cycle line levels.
module tb_serial_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'd0;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'd0;

  logic       rdy0_a, rdy1_a, tx_a, busy_a, grant_a, fd_a;
  logic       rdy0_b, rdy1_b, tx_b, busy_b, grant_b, fd_b;
  logic [1:0] st_a, st_b;
  logic       rdy0_s, rdy1_s, tx_s, busy_s, grant_s, fd_s;

  logic       sel = 1'b0;
  int         bc = 1;
  int         compared = 0;
  int         mismatched = 0;
  int         done_cnt = 0;
  logic       last_grant = 1'b1;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_tx_arbiter #(.BIT_CYCLES(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(rdy0_a),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(rdy1_a),
    .tx(tx_a), .busy(busy_a), .grant_id(grant_a), .frame_done(fd_a), .state_dbg(st_a)
  );

  serial_tx_arbiter #(.BIT_CYCLES(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(rdy0_b),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(rdy1_b),
    .tx(tx_b), .busy(busy_b), .grant_id(grant_b), .frame_done(fd_b), .state_dbg(st_b)
  );

  always_comb begin
    rdy0_s  = sel ? rdy0_b  : rdy0_a;
    rdy1_s  = sel ? rdy1_b  : rdy1_a;
    tx_s    = sel ? tx_b    : tx_a;
    busy_s  = sel ? busy_b  : busy_a;
    grant_s = sel ? grant_b : grant_a;
    fd_s    = sel ? fd_b    : fd_a;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic       window, win, r0, r1;
    logic [7:0] d;
    logic [9:0] bits;
    r0 = 1'b0;
    r1 = 1'b0;
    @(negedge clk);
    if (reset) begin
      check("ready0_in_reset", 8'(rdy0_s), 8'd0);
      check("ready1_in_reset", 8'(rdy1_s), 8'd0);
    end else begin
      window = (exp_q.size() <= 1);
      win    = (req0_valid && req1_valid) ? !last_grant : req1_valid;
      r0     = window && req0_valid && !win;
      r1     = window && req1_valid && win;
      check("tx",         8'(tx_s),    8'(exp_q.size() != 0 ? exp_q[0][0] : 1'b1));
      check("frame_done", 8'(fd_s),    8'(exp_q.size() != 0 ? exp_q[0][1] : 1'b0));
      check("busy",       8'(busy_s),  8'(exp_q.size() != 0));
      check("grant_id",   8'(grant_s), 8'(last_grant));
      check("req0_ready", 8'(rdy0_s),  8'(r0));
      check("req1_ready", 8'(rdy1_s),  8'(r1));
      if (fd_s === 1'b1) done_cnt++;
    end
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      last_grant = 1'b1;
    end else begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (r0 || r1) begin
        d          = r1 ? req1_data : req0_data;
        last_grant = r1;
        bits       = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++)
          for (int c = 0; c < bc; c++)
            exp_q.push_back({(i == 9) && (c == bc - 1), bits[i]});
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic random_traffic(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      cycle();
    end
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  initial begin
    // Single-cycle bits: reset, lone 0xA5 frame
    sel = 1'b0; bc = 1;
    reset = 1'b1; run(3); reset = 1'b0;
    run(1);
    drive(1'b1, 8'hA5, 1'b0, 8'h00); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00); run(12);
    check("grant_after_a5", 8'(grant_s), 8'd0);

    // Contention from reset, held for four back-to-back frames
    reset = 1'b1; cycle(); reset = 1'b0;
    done_cnt = 0;
    drive(1'b1, 8'h11, 1'b1, 8'h22); run(40);
    drive(1'b0, 8'h00, 1'b0, 8'h00); run(12);
    check("four_frames_done", 8'(done_cnt), 8'd4);
    check("grant_after_four", 8'(grant_s), 8'd1);

    // Abort in DATA bit 3, then contention must go to requester 0
    drive(1'b1, 8'h3C, 1'b0, 8'h00); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00); run(4);
    reset = 1'b1; cycle(); reset = 1'b0;
    done_cnt = 0;
    run(2);
    drive(1'b1, 8'h55, 1'b1, 8'hAA); cycle();
    check("grant_after_abort", 8'(grant_s), 8'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00); run(12);

    random_traffic(300);
    run(12);

    // Four-cycle bits: lone 0x80 from requester 1
    sel = 1'b1; bc = 4;
    reset = 1'b1; run(2); reset = 1'b0;
    done_cnt = 0;
    drive(1'b0, 8'h00, 1'b1, 8'h80); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00); run(45);
    check("grant_after_80", 8'(grant_s), 8'd1);
    check("one_frame_bc4", 8'(done_cnt), 8'd1);

    drive(1'b1, 8'hC3, 1'b0, 8'h00); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00); run(16);
    reset = 1'b1; cycle(); reset = 1'b0;
    run(2);
    drive(1'b1, 8'h5A, 1'b1, 8'hA5); cycle();
    check("grant_after_abort_bc4", 8'(grant_s), 8'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00); run(42);

    random_traffic(400);
    run(45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter: BIT_CYCLES, default 1, clocks per serial bit (legal range 1..255).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has a byte to send.
REQ-005 Port: req0_data  input  8  requester 0 byte.
REQ-006 Port: req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 Port: req1_valid  input  1  requester 1 has a byte to send.
REQ-008 Port: req1_data  input  8  requester 1 byte.
REQ-009 Port: req1_ready  output  1  requester 1 byte accepted this cycle.
REQ-010 Port: tx  output  1  shared serial line, idle high, registered.
REQ-011 Port: busy  output  1  frame in progress (state != IDLE).
REQ-012 Port: grant_id  output  1  owner of current/last frame, registered.
REQ-013 Port: frame_done  output  1  one-cycle pulse in final stop-bit cycle.

Function
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, encoded in 2 bits.
REQ-015 Frame format SHALL be: start bit 0, 8 data bits LSB first, stop bit 1; each bit held BIT_CYCLES clocks; total 10*BIT_CYCLES clocks.
REQ-016 Accept window SHALL be: state IDLE, or final cycle of STOP (back-to-back frames, no idle gap).
REQ-017 reqN_ready SHALL be combinational: high only in an accept window when reqN_valid is high and N is the arbitration winner; at most one ready high per cycle.
REQ-018 Arbitration SHALL be round-robin: when both valid, grant the requester not equal to grant_id; when one valid, grant it.
REQ-019 On acceptance, the winner's data SHALL be latched into an 8-bit shift register, grant_id updated to the winner, and state set to START at the next edge.
REQ-020 tx SHALL be 0 throughout START, shift-register bit 0 throughout each DATA bit (register shifted right at each bit boundary), and 1 throughout STOP and IDLE.
REQ-021 A bit counter (0..7) and a cycle counter (0..BIT_CYCLES-1) SHALL sequence DATA; DATA->STOP after bit 7's final cycle; START->DATA and STOP->IDLE/START after BIT_CYCLES cycles.
REQ-022 STOP final cycle: frame_done=1; if an accept occurs, next state START, else IDLE.
REQ-023 Input data changing after acceptance SHALL NOT affect the frame in flight.
REQ-024 valid dropping without ready SHALL be permitted; no request is latched without a ready handshake.
REQ-025 busy SHALL be low only in IDLE.

Reset
REQ-026 Reset SHALL force state IDLE, tx=1, busy=0, frame_done=0, grant_id=1 (so requester 0 wins the first contention), counters and shift register 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame: tx=1 from the next cycle, no frame_done, no ready while reset high.

Verification
REQ-028 BIT_CYCLES=1, req0 sends 0xA5 from idle -> req0_ready 1 cycle; tx = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; frame_done on 10th; grant_id=0.
REQ-029 Both valid from reset with 0x11/0x22 held -> 0x11 (req0) sent first, 0x22 (req1) starts the cycle after req0's stop bit with no idle gap; grant_id 0 then 1.
REQ-030 Both valid continuously for 4 frames -> grants alternate 0,1,0,1; each frame exactly 10 cycles.
REQ-031 BIT_CYCLES=4, req1 sends 0x80 -> tx low 32 cycles (start + 7 zero bits), high 4 (bit 7), high 4 (stop); frame_done in cycle 40.
REQ-032 Reset in DATA bit 3 -> tx=1 next cycle, busy=0, no frame_done; subsequent req1 and req0 both valid -> req0 granted.
REQ-033 req0_data changed mid-frame -> transmitted bits match the byte sampled at the ready cycle.
